pulse_gen: RTL and testbench

Programmable pulse generator; the transmit-side counterpart of the theremin pulse-width detector. Drives `vout` high for a commanded number of ticks, then low for a commanded gap, optionally repeating. One tick = `TICK_DIV` clocks, the same tick the width detector measures in, so a width count written here reads back unchanged at the detector. Used for sensor trigger pulses and for loop-back self-test of the detector.

---
 rtl/theremin_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 34 +++
 rtl/pulse_gen.sv | 128 ++++++++++++
 tb/tb_pulse_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/theremin_pkg.sv
// Shared definitions for the theremin pulse generator and width detector.
// Both ends import the same tick constant so a written width reads back unchanged.
package theremin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pg_state_t;

    localparam int TICK_DIV_DEFAULT = 100;
    localparam int CNT_W_DEFAULT    = 13;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick_o marks the wrap cycle.
// clear_i holds the counter at zero and suppresses the tick.
module tick_prescaler #(
    parameter int TICK_DIV = theremin_pkg::TICK_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick_o = !clear_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_gen.sv
// Programmable pulse generator: vout high for width ticks, low for gap ticks,
// optionally repeating back-to-back.
//   state | meaning
//   IDLE  | waiting for start; vout=0, busy=0
//   HIGH  | driving vout=1, counting width ticks
//   LOW   | driving vout=0, counting gap ticks
module pulse_gen
    import theremin_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] gap_i,
    input  logic             repeat_i,
    input  logic             abort_i,
    output logic             vout_o,
    output logic             busy_o,
    output logic             done_o
);

    pg_state_t        state_q;
    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] gap_q;
    logic             vout_q, busy_q, done_q;

    pg_state_t        ld_state_d;
    logic [CNT_W-1:0] ld_remain_d;
    logic             tick;
    logic             presc_clear;

    // Prescaler restarts from zero on every accept and after abort.
    assign presc_clear = (state_q == IDLE) || abort_i;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (presc_clear),
        .tick_o  (tick)
    );

    // Phase selected when a new period is loaded from the ports.
    always_comb begin
        ld_state_d  = IDLE;
        ld_remain_d = '0;
        if (width_i != '0) begin
            ld_state_d  = HIGH;
            ld_remain_d = width_i;
        end else if (gap_i != '0) begin
            ld_state_d  = LOW;
            ld_remain_d = gap_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            remain_q <= '0;
            gap_q    <= '0;
            vout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        gap_q    <= gap_i;
                        state_q  <= ld_state_d;
                        remain_q <= ld_remain_d;
                        vout_q   <= (ld_state_d == HIGH);
                        busy_q   <= (ld_state_d != IDLE);
                        done_q   <= (ld_state_d == IDLE);
                    end
                end
                HIGH, LOW: begin
                    if (abort_i) begin
                        state_q  <= IDLE;
                        remain_q <= '0;
                        gap_q    <= '0;
                        vout_q   <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (tick) begin
                        if (remain_q == CNT_W'(1)) begin
                            if ((state_q == HIGH) && (gap_q != '0)) begin
                                state_q  <= LOW;
                                remain_q <= gap_q;
                                vout_q   <= 1'b0;
                            end else begin
                                done_q <= 1'b1;
                                if (repeat_i) begin
                                    gap_q    <= gap_i;
                                    state_q  <= ld_state_d;
                                    remain_q <= ld_remain_d;
                                    vout_q   <= (ld_state_d == HIGH);
                                    busy_q   <= (ld_state_d != IDLE);
                                end else begin
                                    state_q  <= IDLE;
                                    remain_q <= '0;
                                    gap_q    <= '0;
                                    vout_q   <= 1'b0;
                                    busy_q   <= 1'b0;
                                end
                            end
                        end else begin
                            remain_q <= remain_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vout_o = vout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen with TICK_DIV=4; includes a behavioural width detector for loop-back.
module tb_pulse_gen;

    localparam int TD = 4;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] width = '0;
    logic [CW-1:0] gap = '0;
    logic          rpt = 1'b0;
    logic          abort = 1'b0;
    logic          vout, busy, done;

    int checks = 0;
    int failures = 0;

    int det_cnt = 0;
    int det_width = 0;

    pulse_gen #(.TICK_DIV(TD), .CNT_W(CW)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .width_i  (width),
        .gap_i    (gap),
        .repeat_i (rpt),
        .abort_i  (abort),
        .vout_o   (vout),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    // Width detector model: measures each high run in ticks.
    always @(posedge clk) begin
        if (vout) begin
            det_cnt <= det_cnt + 1;
        end else if (det_cnt != 0) begin
            det_width <= det_cnt / TD;
            det_cnt   <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Accept one request, then sample n cycles on the falling edge.
    task automatic run_shot(input logic [CW-1:0] w, input logic [CW-1:0] g, input int n,
                            output int hi, output int bz, output int dn, output int dnb,
                            output int v0, output int b0);
        hi = 0; bz = 0; dn = 0; dnb = 0; v0 = 0; b0 = 0;
        @(negedge clk);
        width = w; gap = g; start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 0) begin
                v0 = int'(vout);
                b0 = int'(busy);
            end
            if (vout) hi++;
            if (busy) bz++;
            if (done) dn++;
            if (done && busy) dnb++;
        end
    endtask

    typedef struct {
        logic [CW-1:0] w;
        logic [CW-1:0] g;
        int            hi;
        int            bz;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int hi, bz, dn, dnb, v0, b0, errs;

        vecs[0] = '{w: 13'd3, g: 13'd2, hi: 12, bz: 20};
        vecs[1] = '{w: 13'd0, g: 13'd5, hi: 0,  bz: 20};
        vecs[2] = '{w: 13'd2, g: 13'd0, hi: 8,  bz: 8};
        vecs[3] = '{w: 13'd0, g: 13'd0, hi: 0,  bz: 0};
        vecs[4] = '{w: 13'd1, g: 13'd1, hi: 4,  bz: 8};
        vecs[5] = '{w: 13'd5, g: 13'd3, hi: 20, bz: 32};

        repeat (3) @(negedge clk);
        chk("reset_vout", int'(vout), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_shot(vecs[k].w, vecs[k].g, (int'(vecs[k].w) + int'(vecs[k].g)) * TD + 8,
                     hi, bz, dn, dnb, v0, b0);
            chk($sformatf("vec%0d_high_clks", k), hi, vecs[k].hi);
            chk($sformatf("vec%0d_busy_clks", k), bz, vecs[k].bz);
            chk($sformatf("vec%0d_done_count", k), dn, 1);
            chk($sformatf("vec%0d_done_while_busy", k), dnb, 0);
            chk($sformatf("vec%0d_first_vout", k), v0, (vecs[k].hi != 0) ? 1 : 0);
            chk($sformatf("vec%0d_first_busy", k), b0, (vecs[k].bz != 0) ? 1 : 0);
            if (vecs[k].bz == 0) chk($sformatf("vec%0d_done_at_accept", k), int'(done), 0);
        end

        // Repeat: three contiguous 1/1 periods, repeat dropped before the third end.
        errs = 0; dn = 0;
        @(negedge clk);
        width = 13'd1; gap = 13'd1; rpt = 1'b1; start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i < 24 && vout != ((i % 8) < 4)) errs++;
            if (i >= 24 && (vout || busy)) errs++;
            if (done) begin
                dn++;
                if (!((i == 8) || (i == 16) || (i == 24))) errs++;
                if (busy != (i < 24)) errs++;
            end
            if (i == 20) rpt = 1'b0;
        end
        chk("repeat_wave_errors", errs, 0);
        chk("repeat_done_count", dn, 3);

        // Abort at clock 5 of a width=10 pulse.
        dn = 0;
        @(negedge clk);
        width = 13'd10; gap = 13'd0; start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dn++;
            if (i == 4) begin
                chk("abort_pre_vout", int'(vout), 1);
                abort = 1'b1;
            end
            if (i == 5) begin
                chk("abort_vout", int'(vout), 0);
                chk("abort_busy", int'(busy), 0);
                abort = 1'b0;
            end
        end
        chk("abort_no_done", dn, 0);

        // Start during a pulse is ignored.
        hi = 0; bz = 0; dn = 0;
        @(negedge clk);
        width = 13'd3; gap = 13'd0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (vout) hi++;
            if (busy) bz++;
            if (done) dn++;
            if (i == 2) begin
                start = 1'b1; width = 13'd1; gap = 13'd1;
            end
        end
        chk("ignored_start_high", hi, 12);
        chk("ignored_start_busy", bz, 12);
        chk("ignored_start_done", dn, 1);

        // Abort on the final edge wins over done.
        dn = 0;
        @(negedge clk);
        width = 13'd2; gap = 13'd0; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dn++;
            if (i == 7) abort = 1'b1;
            if (i == 8) begin
                chk("abort_final_busy", int'(busy), 0);
                abort = 1'b0;
            end
        end
        chk("abort_final_no_done", dn, 0);

        // Abort in IDLE blocks acceptance.
        bz = 0; dn = 0;
        @(negedge clk);
        width = 13'd2; gap = 13'd1; start = 1'b1; abort = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy) bz++;
            if (done) dn++;
        end
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", bz, 0);
        chk("idle_abort_done", dn, 0);

        // Asynchronous reset mid-HIGH, then max-width pulse.
        @(negedge clk);
        width = 13'd5; gap = 13'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_vout", int'(vout), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_vout", int'(vout), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_done", int'(done), 0);
        width = 13'd8191; gap = 13'd0; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 32764 + 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 0) chk("first_accept_after_reset", int'(vout), 1);
            if (vout) hi++;
        end
        chk("max_width_high_clks", hi, 32764);

        // Loop-back into the width detector model.
        run_shot(13'd37, 13'd5, 42 * TD + 8, hi, bz, dn, dnb, v0, b0);
        chk("loopback_high_clks", hi, 148);
        chk("loopback_detector", det_width, 37);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
